// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// memory depth and the byte-insert helper used by the word assembler.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

  // Place byte b into lane k of word w (lane 0 = bits [7:0]).
  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  k,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wd
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wd
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes little-endian into a 32-bit word; o_word is the value
// including the byte being pushed so the top can capture it on the 4th push.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  assign o_word = insert_byte(r_word, r_cnt, i_byte);
  assign o_full = i_push && (r_cnt == 2'd3);

  // Byte counter and partial word; the counter wraps to 0 after a full word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clr) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_push) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: takes a header count plus N little-endian words from a byte
// stream, writes them to instruction memory and releases the core when done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err
);

  loader_state_t r_state, w_next;
  logic [CNT_W-1:0] r_n, r_word_idx;
  logic             r_byte_ready, r_we, r_done, r_err, r_cpu_rst_n;
  logic [31:0]      r_addr, r_wd;
  logic             w_accept, w_hdr_bad, w_push, w_clr, w_full, w_idx_last;
  logic [31:0]      w_word;

  assign w_accept   = bus.byte_valid && r_byte_ready;
  assign w_hdr_bad  = (bus.byte_in == 8'd0) || (32'(bus.byte_in) > 32'(DEPTH));
  assign w_push     = w_accept && (r_state == DATA);
  assign w_clr      = w_accept && (r_state == HDR);
  assign w_idx_last = ((r_word_idx + CNT_W'(1)) == r_n);

  imem_loader_word_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_push (w_push),
    .i_byte (bus.byte_in),
    .o_word (w_word),
    .o_full (w_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = HDR; else w_next = IDLE;
      HDR: begin
        if (w_accept) w_next = w_hdr_bad ? ERR : DATA;
        else          w_next = HDR;
      end
      DATA:    if (w_full) w_next = WRITE; else w_next = DATA;
      WRITE:   if (w_idx_last) w_next = DONE; else w_next = DATA;
      DONE:    if (start) w_next = HDR; else w_next = DONE;
      ERR:     if (start) w_next = HDR; else w_next = ERR;
      default: w_next = IDLE;
    endcase
  end

  // Header count and word index; the index stops at N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n        <= '0;
      r_word_idx <= '0;
    end else if (w_clr) begin
      r_n        <= CNT_W'(bus.byte_in);
      r_word_idx <= '0;
    end else if ((r_state == WRITE) && !w_idx_last) begin
      r_word_idx <= r_word_idx + CNT_W'(1);
    end
  end

  // Outputs registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
      r_addr       <= 32'd0;
      r_wd         <= 32'd0;
    end else begin
      r_byte_ready <= (w_next == HDR) || (w_next == DATA);
      r_we         <= (w_next == WRITE);
      r_done       <= (w_next == DONE);
      r_err        <= (w_next == ERR);
      r_cpu_rst_n  <= (w_next == DONE);
      if (w_full) begin
        r_addr <= 32'({r_word_idx, 2'b00});
        r_wd   <= w_word;
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wd    = r_wd;
  assign cpu_rst_n      = r_cpu_rst_n;
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by a monitor whenever the write strobe is seen.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rst_n, done, err;

  imem_loader_if bus();

  imem_loader #(.DEPTH(64), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_e;
  bit          in_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", bus.imem_addr, mon_e[63:32]);
        chk("wr_data", bus.imem_wd, mon_e[31:0]);
      end
    end
    if (in_load && !done && !err)
      chk("ready_vs_write", {31'd0, bus.byte_ready}, {31'd0, !bus.imem_we});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!done && !err && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("end_timeout", 32'd0, 32'd1);
    in_load = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, bus.imem_we},    32'd0);
    chk({tag, "_addr"},  bus.imem_addr,           32'd0);
    chk({tag, "_wd"},    bus.imem_wd,             32'd0);
    chk({tag, "_cpurst"},{31'd0, cpu_rst_n},      32'd0);
    chk({tag, "_done"},  {31'd0, done},           32'd0);
    chk({tag, "_err"},   {31'd0, err},            32'd0);
  endtask

  logic [31:0] gap_words [3] = '{32'h11223344, 32'hA5A55A5A, 32'h0BADC0DE};
  logic [31:0] gw;

  initial begin
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Normal load; valid already high with start in IDLE must not be consumed.
    sb.push_back({32'h0, 32'hDEADBEEF});
    sb.push_back({32'h4, 32'h12345678});
    bus.byte_in = 8'h02; bus.byte_valid = 1'b1;
    pulse_start();
    in_load = 1'b1;
    send_byte(8'h02);
    send_word(32'hDEADBEEF, 0);
    send_word(32'h12345678, 0);
    wait_end();
    chk("norm_done",   {31'd0, done},      32'd1);
    chk("norm_cpurst", {31'd0, cpu_rst_n}, 32'd1);
    chk("norm_err",    {31'd0, err},       32'd0);
    chk("norm_sb",     sb.size(),          32'd0);

    // Reload from DONE, then N=0 header.
    pulse_start();
    chk("reload_cpurst", {31'd0, cpu_rst_n}, 32'd0);
    chk("reload_done",   {31'd0, done},      32'd0);
    in_load = 1'b1;
    send_byte(8'h00);
    wait_end();
    chk("n0_err",    {31'd0, err},       32'd1);
    chk("n0_cpurst", {31'd0, cpu_rst_n}, 32'd0);

    // N=DEPTH+1 header.
    pulse_start();
    chk("n65_errclr", {31'd0, err}, 32'd0);
    in_load = 1'b1;
    send_byte(8'd65);
    wait_end();
    chk("n65_err", {31'd0, err}, 32'd1);

    // Recovery with N=1.
    sb.push_back({32'h0, 32'hCAFEF00D});
    pulse_start();
    in_load = 1'b1;
    send_byte(8'd1);
    send_word(32'hCAFEF00D, 0);
    wait_end();
    chk("n1_done", {31'd0, done}, 32'd1);
    chk("n1_err",  {31'd0, err},  32'd0);

    // Gaps in valid plus start pulses during DATA/WRITE that must be ignored.
    for (int i = 0; i < 3; i++) sb.push_back({32'(4 * i), gap_words[i]});
    pulse_start();
    in_load = 1'b1;
    send_byte(8'd3);
    for (int i = 0; i < 12; i++) begin
      gw = gap_words[i / 4];
      repeat ((i * 3) % 4) @(negedge clk);
      if (i == 4 || i == 5) pulse_start();
      send_byte(gw[8 * (i % 4) +: 8]);
    end
    wait_end();
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_sb",   sb.size(),     32'd0);

    // Full depth, data = word index.
    for (int i = 0; i < 64; i++) sb.push_back({32'(4 * i), 32'(i)});
    pulse_start();
    in_load = 1'b1;
    send_byte(8'd64);
    for (int i = 0; i < 64; i++) send_word(32'(i), 0);
    wait_end();
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_sb",   sb.size(),     32'd0);

    // Reset mid-DATA after two of four words.
    sb.push_back({32'h0, 32'h01020304});
    sb.push_back({32'h4, 32'h05060708});
    pulse_start();
    in_load = 1'b1;
    send_byte(8'd4);
    send_word(32'h01020304, 0);
    send_word(32'h05060708, 0);
    send_byte(8'h77);
    chk("mid_sb", sb.size(), 32'd0);
    in_load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b1;
    bus.byte_in = 8'h55; bus.byte_valid = 1'b1;
    repeat (20) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("post_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("post_done",  {31'd0, done},           32'd0);
    chk("post_sb",    sb.size(),               32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
